// File: rtl/intmatvec_seq_engine_pkg.sv
// rtl/intmatvec_seq_engine_pkg.sv - shared constants and types for the sequential matrix-vector engine
// Contents: bus address map, FSM state encoding, control/status bit positions.
package intmatvec_seq_engine_pkg;

  localparam logic [14:0] ADDR_MAT      = 15'd0;
  localparam logic [14:0] ADDR_VEC      = 15'd1;
  localparam logic [14:0] ADDR_CTRL     = 15'd2;
  localparam logic [14:0] ADDR_STAT     = 15'd3;
  localparam logic [14:0] ADDR_RES_BASE = 15'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } engineState_t;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_SIGNED_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

endpackage

// File: rtl/intmatvec_seq_engine_mac_lane.sv
// rtl/intmatvec_seq_engine_mac_lane.sv - one row multiply-accumulate lane
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   Elem, VecWord  matrix element M[r][c] and vector word V[c] for the current column
//   SignedMode     1 = two's-complement operands, 0 = unsigned
//   Clear          zero the accumulator (start of a run)
//   Enable         accumulate Elem*VecWord this cycle
//   Acc            running row sum, wraps modulo 2^pAccWidth
module intmatvec_mac_lane #(
  parameter int pWordSize = 8,
  parameter int pAccWidth = 19
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [pWordSize-1:0] Elem,
  input  logic [pWordSize-1:0] VecWord,
  input  logic                 SignedMode,
  input  logic                 Clear,
  input  logic                 Enable,
  output logic [pAccWidth-1:0] Acc
);

  logic [pAccWidth-1:0] elemExt;
  logic [pAccWidth-1:0] vecExt;
  logic [pAccWidth-1:0] product;

  // Extending both operands to the accumulator width before multiplying gives
  // the exact product modulo 2^pAccWidth in either mode, so one multiplier serves both.
  always_comb begin
    elemExt = SignedMode ? pAccWidth'($signed(Elem))    : pAccWidth'(Elem);
    vecExt  = SignedMode ? pAccWidth'($signed(VecWord)) : pAccWidth'(VecWord);
    product = elemExt * vecExt;
  end

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      Acc <= '0;
    end else if (Enable) begin
      Acc <= Acc + product;
    end
  end

endmodule

// File: rtl/intmatvec_seq_engine.sv
// rtl/intmatvec_seq_engine.sv - bus-slave sequential integer matrix-vector multiplier
// Ports:
//   Clk, Reset  clock and synchronous active-high reset
//   RD, WR      bus read / write strobes
//   Addr        15-bit bus address (0 matrix scan, 1 vector scan, 2 control, 3 status, 4.. rows)
//   DataIn      32-bit write data
//   DataOut     32-bit read data, high impedance while RD is low
module intmatvec_seq_engine
  import intmatvec_seq_engine_pkg::*;
#(
  parameter int pVectorSize = 8,
  parameter int pWordSize   = 8,
  parameter int pAccWidth   = 2 * pWordSize + $clog2(pVectorSize)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RD,
  input  logic        WR,
  input  logic [14:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut
);

  localparam int NumWords = pVectorSize * pVectorSize;
  localparam int ColWidth = $clog2(pVectorSize);

  logic [pWordSize-1:0] matWords [NumWords];
  logic [pWordSize-1:0] vecWords [pVectorSize];
  logic [pWordSize-1:0] rowElems [pVectorSize];
  logic [pWordSize-1:0] vecSel;
  logic [pAccWidth-1:0] accs     [pVectorSize];

  engineState_t         state, nextState;
  logic [ColWidth-1:0]  col;
  logic                 signedMode, doneFlag, errFlag;
  logic                 busy, startCmd, laneClear, laneEnable, lastCol;
  logic                 wrMat, wrVec, wrCtrl, wrStat;
  logic [31:0]          readData;
  logic                 unusedDataIn;

  assign unusedDataIn = ^DataIn;

  assign wrMat  = WR && (Addr == ADDR_MAT);
  assign wrVec  = WR && (Addr == ADDR_VEC);
  assign wrCtrl = WR && (Addr == ADDR_CTRL);
  assign wrStat = WR && (Addr == ADDR_STAT);
  assign lastCol = (col == ColWidth'(pVectorSize - 1));

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM: next state
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE, ST_DONE: if (startCmd) nextState = ST_RUN;
      ST_RUN:           if (lastCol)  nextState = ST_DONE;
      default:          nextState = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy       = (state == ST_RUN);
    startCmd   = wrCtrl && DataIn[CTRL_START_BIT] && (state != ST_RUN);
    laneClear  = startCmd;
    laneEnable = busy;
  end

  // Scan registers: each write shifts toward index 0 and inserts at the top,
  // so after a full load the first word written sits at index 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < NumWords; k++) matWords[k] <= '0;
      for (int k = 0; k < pVectorSize; k++) vecWords[k] <= '0;
    end else begin
      if (wrMat && !busy) begin
        for (int k = 0; k < NumWords - 1; k++) matWords[k] <= matWords[k+1];
        matWords[NumWords-1] <= DataIn[pWordSize-1:0];
      end
      if (wrVec && !busy) begin
        for (int k = 0; k < pVectorSize - 1; k++) vecWords[k] <= vecWords[k+1];
        vecWords[pVectorSize-1] <= DataIn[pWordSize-1:0];
      end
    end
  end

  // Column counter, mode latch and sticky status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      col        <= '0;
      signedMode <= 1'b0;
      doneFlag   <= 1'b0;
      errFlag    <= 1'b0;
    end else begin
      if (startCmd) begin
        col        <= '0;
        signedMode <= DataIn[CTRL_SIGNED_BIT];
      end else if (busy) begin
        col <= lastCol ? '0 : col + ColWidth'(1);
      end

      if (busy && lastCol) begin
        doneFlag <= 1'b1;
      end else if (startCmd || wrStat) begin
        doneFlag <= 1'b0;
      end

      if (busy && (wrMat || wrVec || wrCtrl)) begin
        errFlag <= 1'b1;
      end else if (wrStat) begin
        errFlag <= 1'b0;
      end
    end
  end

  // Column select: constant indices keep the mux free of variable-width array indexing.
  always_comb begin
    vecSel = '0;
    for (int r = 0; r < pVectorSize; r++) rowElems[r] = '0;
    for (int c = 0; c < pVectorSize; c++) begin
      if (col == ColWidth'(c)) begin
        vecSel = vecWords[c];
        for (int r = 0; r < pVectorSize; r++) rowElems[r] = matWords[r*pVectorSize + c];
      end
    end
  end

  for (genvar r = 0; r < pVectorSize; r++) begin : gLane
    intmatvec_mac_lane #(
      .pWordSize (pWordSize),
      .pAccWidth (pAccWidth)
    ) uLane (
      .Clk        (Clk),
      .Reset      (Reset),
      .Elem       (rowElems[r]),
      .VecWord    (vecSel),
      .SignedMode (signedMode),
      .Clear      (laneClear),
      .Enable     (laneEnable),
      .Acc        (accs[r])
    );
  end

  // Read decode: results extend according to the mode latched at start.
  always_comb begin
    readData = '0;
    if (Addr == ADDR_CTRL) begin
      readData[CTRL_SIGNED_BIT] = signedMode;
    end else if (Addr == ADDR_STAT) begin
      readData[STAT_BUSY_BIT] = busy;
      readData[STAT_DONE_BIT] = doneFlag;
      readData[STAT_ERR_BIT]  = errFlag;
    end else begin
      for (int r = 0; r < pVectorSize; r++) begin
        if (Addr == ADDR_RES_BASE + 15'(r)) begin
          readData = signedMode ? 32'($signed(accs[r])) : 32'(accs[r]);
        end
      end
    end
  end

  assign DataOut = RD ? readData : {32{1'bz}};

endmodule

// File: tb/tb_intmatvec_seq_engine.sv
// tb/tb_intmatvec_seq_engine.sv - scoreboard bench for intmatvec_seq_engine
module tb_intmatvec_seq_engine;

  localparam int N = 8;
  localparam int W = 8;
  localparam int A = 2 * W + $clog2(N);

  logic        Clk = 1'b0;
  logic        Reset, RD, WR;
  logic [14:0] Addr;
  logic [31:0] DataIn;
  wire  [31:0] DataOut;

  always #5 Clk = ~Clk;

  intmatvec_seq_engine #(.pVectorSize(N), .pWordSize(W)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .RD      (RD),
    .WR      (WR),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] expQ[$];
  string       nameQ[$];

  // Reference model: the last N*N / N words written, mode of the current run.
  int matQ[$];
  int vecQ[$];
  bit mdlSigned;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge Clk) begin
    if (RD === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected none", DataOut);
      end else begin
        check(nameQ.pop_front(), DataOut, expQ.pop_front());
      end
    end
  end

  function automatic void mdlReset();
    matQ.delete();
    vecQ.delete();
    repeat (N*N) matQ.push_back(0);
    repeat (N) vecQ.push_back(0);
    mdlSigned = 1'b0;
  endfunction

  function automatic longint opVal(int raw);
    if (mdlSigned && raw >= (1 << (W-1))) return longint'(raw) - (longint'(1) << W);
    return longint'(raw);
  endfunction

  function automatic logic [31:0] mdlRow(int r);
    longint     s = 0;
    logic [63:0] u, mask;
    for (int c = 0; c < N; c++) s += opVal(matQ[r*N + c]) * opVal(vecQ[c]);
    mask = (64'd1 << A) - 64'd1;
    u = 64'(s) & mask;
    if (mdlSigned && u[A-1]) u = u | ~mask;
    return u[31:0];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [31:0] d);
    Addr = a; DataIn = d; WR = 1'b1;
    tick();
    WR = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, input logic [31:0] exp, input string nm);
    Addr = a; RD = 1'b1;
    expQ.push_back(exp);
    nameQ.push_back(nm);
    tick();
    RD = 1'b0;
  endtask

  task automatic scanMat(input int d);
    wr(15'd0, 32'(d));
    matQ.push_back(d & ((1 << W) - 1));
    void'(matQ.pop_front());
  endtask

  task automatic scanVec(input int d);
    wr(15'd1, 32'(d));
    vecQ.push_back(d & ((1 << W) - 1));
    void'(vecQ.pop_front());
  endtask

  task automatic start(input bit sgn);
    wr(15'd2, {30'd0, sgn, 1'b1});
    mdlSigned = sgn;
  endtask

  task automatic checkRows(input string tag);
    for (int r = 0; r < N; r++) rd(15'(4 + r), mdlRow(r), $sformatf("%s_row%0d", tag, r));
  endtask

  task automatic runAndCheck(input bit sgn, input string tag);
    start(sgn);
    repeat (N) tick();
    rd(15'd3, 32'h2, {tag, "_status"});
    rd(15'd2, {30'd0, sgn, 1'b0}, {tag, "_ctrl"});
    checkRows(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; RD = 1'b0; WR = 1'b0; Addr = '0; DataIn = '0;
    mdlReset();
    repeat (2) tick();
    Reset = 1'b0;

    // Reset state
    rd(15'd3, 32'h0, "rst_status");
    rd(15'd2, 32'h0, "rst_ctrl");
    checkRows("rst");

    // Identity matrix, vector 1..N, with exact busy window
    for (int k = 0; k < N*N; k++) scanMat((k / N == k % N) ? 1 : 0);
    for (int c = 0; c < N; c++) scanVec(c + 1);
    start(1'b0);
    for (int i = 0; i <= N; i++) rd(15'd3, (i < N) ? 32'h1 : 32'h2, $sformatf("ident_busy%0d", i));
    checkRows("ident");
    rd(15'(4 + N - 1), 32'(N), "ident_last_const");
    rd(15'(4 + N), 32'h0, "unmapped_row");
    rd(15'h7fff, 32'h0, "unmapped_high");
    Addr = 15'(4 + N - 1);
    #2;
    checks++;
    if (!(DataOut === {32{1'bz}} || DataOut === 32'h0)) begin
      errors++;
      $display("FAIL rd_low_release: got %h expected z", DataOut);
    end
    tick();

    // All-ones operands in both modes
    for (int k = 0; k < N*N; k++) scanMat(32'hFF);
    for (int c = 0; c < N; c++) scanVec(32'hFF);
    runAndCheck(1'b0, "ffu");
    rd(15'd4, 32'h0007F008, "ffu_const");
    runAndCheck(1'b1, "ffs");
    rd(15'd4, 32'h00000008, "ffs_const");
    for (int c = 0; c < N; c++) scanVec(32'h01);
    runAndCheck(1'b1, "ff01s");
    rd(15'd4, 32'hFFFFFFF8, "ff01s_const");

    // Matrix write while busy is ignored and flags err
    for (int k = 0; k < N*N; k++) scanMat($urandom);
    for (int c = 0; c < N; c++) scanVec($urandom);
    start(1'b0);
    tick(); tick();
    wr(15'd0, 32'h55);
    repeat (N - 3) tick();
    rd(15'd3, 32'h6, "err_status");
    checkRows("err");
    Addr = 15'd3; DataIn = 32'h0; RD = 1'b1; WR = 1'b1;
    expQ.push_back(32'h6); nameQ.push_back("rdwr_preedge");
    tick();
    RD = 1'b0; WR = 1'b0;
    rd(15'd3, 32'h0, "status_cleared");
    checkRows("errclr");

    // Reset during a run
    start(1'b1);
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mdlReset();
    rd(15'd3, 32'h0, "rstrun_status");
    rd(15'd2, 32'h0, "rstrun_ctrl");
    checkRows("rstrun");
    runAndCheck(1'b1, "rstrun_noload");

    // Random data, then restart from DONE with a fresh vector
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < N*N; k++) scanMat($urandom);
      for (int c = 0; c < N; c++) scanVec($urandom);
      runAndCheck(1'($urandom), $sformatf("rnd%0d", it));
      for (int c = 0; c < N; c++) scanVec($urandom);
      runAndCheck(1'($urandom), $sformatf("rnd%0d_restart", it));
    end

    tick();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
